// File: rtl/req_encoder_if.sv
// req_encoder_if: request/index handshake bundle between interrupt sources, encoder and control unit
interface req_encoder_if;
    logic [7:0] req;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_valid;
    logic [7:0] pending;
    logic       ovf;
    modport master (output req, out_ready, input out_idx, out_valid, pending, ovf);
    modport slave (input req, out_ready, output out_idx, out_valid, pending, ovf);
endinterface

// File: rtl/req_encoder_8to3.sv
// req_encoder_8to3: sticky 8-line request latch served one 3-bit index at a time over valid/ready
// Define REQ_ENC_ROUND_ROBIN_EN for rotating-pointer arbitration instead of fixed priority
module req_encoder_8to3 #(
    parameter bit PRIO_LOW_FIRST = 1'b1
) (
    input logic          clk,
    input logic          rst,
    req_encoder_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t     state, state_nxt;
    logic [7:0] pend, clr;
    logic [2:0] idx, idx_nxt, enc;
    logic       valid, valid_nxt, ovf, accept;
    assign accept = valid & bus.out_ready;
    assign clr    = accept ? 8'd1 << idx : 8'd0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
    logic [2:0] ptr;
    always_ff @(posedge clk) begin
        if (rst) ptr <= 3'd0;
        else if (accept) ptr <= idx + 3'd1;
    end
    // scan downward so the set bit closest to ptr is the last one written
    always_comb begin
        enc = ptr;
        for (int i = 7; i >= 0; i--) begin
            if (pend[ptr + 3'(i)]) enc = ptr + 3'(i);
        end
    end
`else
    always_comb begin
        enc = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend[PRIO_LOW_FIRST ? 7 - i : i]) enc = 3'(PRIO_LOW_FIRST ? 7 - i : i);
        end
    end
`endif
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        valid_nxt = valid;
        if (state == IDLE && pend != 8'd0) begin
            state_nxt = HOLD;
            idx_nxt   = enc;
            valid_nxt = 1'b1;
        end else if (state == HOLD && bus.out_ready) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend  <= 8'd0;
            idx   <= 3'd0;
            valid <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            pend  <= (pend & ~clr) | bus.req;
            idx   <= idx_nxt;
            valid <= valid_nxt;
            ovf   <= |(bus.req & pend & ~clr);
        end
    end
    assign bus.out_idx   = idx;
    assign bus.out_valid = valid;
    assign bus.pending   = pend;
    assign bus.ovf       = ovf;
endmodule
